// File: rtl/capture_ctrl.sv
// Capture sequencer for the 8-channel logic analyzer. It paces the sampler, fills a circular
// capture RAM and stops a fixed number of samples after a masked level/edge trigger.
module capture_ctrl #(
    parameter int unsigned DEPTH_W = 10,
    parameter int unsigned DIV_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               arm,
    input  logic               abort,
    input  logic [DIV_W-1:0]   div,
    input  logic [DEPTH_W-1:0] pre_count,
    input  logic [7:0]         trig_mask,
    input  logic [7:0]         trig_value,
    input  logic               trig_edge,
    output logic               samp_enable,
    input  logic [7:0]         samp_data,
    input  logic               samp_valid,
    output logic               wr_en,
    output logic [DEPTH_W-1:0] wr_addr,
    output logic [7:0]         wr_data,
    output logic               busy,
    output logic               triggered,
    output logic               done,
    output logic [DEPTH_W-1:0] trig_addr,
    output logic [DEPTH_W-1:0] start_addr
);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWait,
        StPost,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Shadow copies of the configuration, captured only on an accepted arm
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DEPTH_W-1:0] pre_q, pre_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         value_q, value_d;
    logic               edge_q, edge_d;

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DEPTH_W-1:0] ptr_q, ptr_d;
    logic [DEPTH_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [DEPTH_W-1:0] post_rem_q, post_rem_d;
    logic [7:0]         prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               triggered_q, triggered_d;
    logic [DEPTH_W-1:0] trig_addr_q, trig_addr_d;

    logic               busy_w;
    logic               wr_w;
    logic               cur_match;
    logic               prev_match;
    logic               trig_hit;
    logic [DEPTH_W-1:0] post_len;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            div_q       <= '0;
            pre_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            edge_q      <= 1'b0;
            div_cnt_q   <= '0;
            ptr_q       <= '0;
            pre_cnt_q   <= '0;
            post_rem_q  <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            triggered_q <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pre_q       <= pre_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            edge_q      <= edge_d;
            div_cnt_q   <= div_cnt_d;
            ptr_q       <= ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_rem_q  <= post_rem_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            triggered_q <= triggered_d;
            trig_addr_q <= trig_addr_d;
        end
    end

    always_comb begin
        busy_w     = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
        wr_w       = samp_valid && busy_w;
        cur_match  = ((samp_data ^ value_q) & mask_q) == 8'h00;
        prev_match = ((prev_q ^ value_q) & mask_q) == 8'h00;
        // Edge mode needs a written predecessor that did not match
        trig_hit   = wr_w && (state_q == StWait) &&
                     (edge_q ? (cur_match && prev_vld_q && !prev_match) : cur_match);
        // Samples still to be kept after the trigger sample fills the rest of the RAM
        post_len   = {DEPTH_W{1'b1}} - pre_q;
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        pre_d       = pre_q;
        mask_d      = mask_q;
        value_d     = value_q;
        edge_d      = edge_q;
        div_cnt_d   = div_cnt_q;
        ptr_d       = ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_rem_d  = post_rem_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        triggered_d = triggered_q;
        trig_addr_d = trig_addr_q;

        if (busy_w) begin
            div_cnt_d = (div_cnt_q == div_q) ? '0 : div_cnt_q + DIV_W'(1);
        end

        // The write of the current cycle lands even when abort is asserted
        if (wr_w) begin
            ptr_d      = ptr_q + DEPTH_W'(1);
            prev_d     = samp_data;
            prev_vld_d = 1'b1;
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        div_d       = div;
                        pre_d       = pre_count;
                        mask_d      = trig_mask;
                        value_d     = trig_value;
                        edge_d      = trig_edge;
                        div_cnt_d   = '0;
                        ptr_d       = '0;
                        pre_cnt_d   = '0;
                        post_rem_d  = '0;
                        prev_d      = '0;
                        prev_vld_d  = 1'b0;
                        triggered_d = 1'b0;
                        state_d     = (pre_count == '0) ? StWait : StPre;
                    end
                end
                StPre: begin
                    if (wr_w) begin
                        pre_cnt_d = pre_cnt_q + DEPTH_W'(1);
                        if (pre_cnt_d == pre_q) begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        trig_addr_d = ptr_q;
                        if (post_len == '0) begin
                            state_d = StDone;
                        end else begin
                            post_rem_d = post_len;
                            state_d    = StPost;
                        end
                    end
                end
                StPost: begin
                    if (wr_w) begin
                        post_rem_d = post_rem_q - DEPTH_W'(1);
                        if (post_rem_q == DEPTH_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign samp_enable = busy_w && (div_cnt_q == '0);
    assign wr_en       = wr_w;
    assign wr_addr     = ptr_q;
    assign wr_data     = samp_data;
    assign busy        = busy_w;
    assign done        = (state_q == StDone);
    assign triggered   = triggered_q;
    assign trig_addr   = trig_addr_q;
    // At least N samples were written, so the pointer now indexes the oldest one
    assign start_addr  = (state_q == StDone) ? ptr_q : '0;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a sampler model, a write monitor and a RAM shadow.
module tb_capture_ctrl;

    localparam int unsigned DEPTH_W = 4;
    localparam int unsigned DIV_W   = 16;
    localparam int          N       = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               arm;
    logic               abort;
    logic [DIV_W-1:0]   div;
    logic [DEPTH_W-1:0] pre_count;
    logic [7:0]         trig_mask;
    logic [7:0]         trig_value;
    logic               trig_edge;
    logic               samp_enable;
    logic [7:0]         samp_data;
    logic               samp_valid;
    logic               wr_en;
    logic [DEPTH_W-1:0] wr_addr;
    logic [7:0]         wr_data;
    logic               busy;
    logic               triggered;
    logic               done;
    logic [DEPTH_W-1:0] trig_addr;
    logic [DEPTH_W-1:0] start_addr;

    capture_ctrl #(
        .DEPTH_W(DEPTH_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm),
        .abort      (abort),
        .div        (div),
        .pre_count  (pre_count),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .samp_enable(samp_enable),
        .samp_data  (samp_data),
        .samp_valid (samp_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Three-segment input pattern indexed by sample number
    logic [7:0] pd0, pd1, pd2;
    int         pi1, pi2;

    function automatic logic [7:0] pat_of(input int idx);
        if (idx < pi1) return pd0;
        if (idx < pi2) return pd1;
        return pd2;
    endfunction

    logic clr;
    int   smp_idx;

    // Sampler model: valid and data one cycle after enable
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            samp_valid <= 1'b0;
            samp_data  <= 8'h00;
            smp_idx    <= 0;
        end else if (clr) begin
            samp_valid <= 1'b0;
            smp_idx    <= 0;
        end else begin
            samp_valid <= samp_enable;
            if (samp_enable) begin
                samp_data <= pat_of(smp_idx);
                smp_idx   <= smp_idx + 1;
            end
        end
    end

    int                 cyc = 0;
    int                 wr_count, gap_err, addr_err, first_wr, last_wr, gap;
    logic [DEPTH_W-1:0] exp_ptr;
    logic [7:0]         mem [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            wr_count <= 0;
            gap_err  <= 0;
            addr_err <= 0;
            exp_ptr  <= '0;
        end else if (wr_en) begin
            if (wr_addr != exp_ptr) addr_err <= addr_err + 1;
            if (wr_count == 0) first_wr <= cyc;
            else if (cyc - last_wr != gap) gap_err <= gap_err + 1;
            last_wr      <= cyc;
            mem[wr_addr] <= wr_data;
            exp_ptr      <= exp_ptr + 1'b1;
            wr_count     <= wr_count + 1;
        end
    end

    int arm_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_arm(input logic [DIV_W-1:0] d, input logic [DEPTH_W-1:0] p,
                          input logic [7:0] m, input logic [7:0] v, input logic e);
        clr = 1'b1;
        tick();
        clr        = 1'b0;
        div        = d;
        pre_count  = p;
        trig_mask  = m;
        trig_value = v;
        trig_edge  = e;
        gap        = int'(d) + 1;
        arm        = 1'b1;
        @(negedge clk);
        arm_cyc = cyc;
        tick();
        arm = 1'b0;
        // Scramble config to show it is only sampled on the arm cycle
        div        = 16'd7;
        pre_count  = ~p;
        trig_mask  = ~m;
        trig_value = ~v;
        trig_edge  = ~e;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_writes(input string name, input int n);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (wr_count >= n) break;
        end
        check(name, {31'd0, wr_count >= n}, 32'd1);
    endtask

    typedef struct {
        logic [DIV_W-1:0]   div;
        logic [DEPTH_W-1:0] pre;
        logic [7:0]         mask;
        logic [7:0]         value;
        logic               edge_mode;
        logic [7:0]         d0;
        logic [7:0]         d1;
        logic [7:0]         d2;
        int                 i1;
        int                 i2;
        logic [DEPTH_W-1:0] exp_trig;
        logic [DEPTH_W-1:0] exp_start;
        int                 exp_writes;
        logic [7:0]         exp_tdat;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int k, input vec_t v);
        pd0 = v.d0; pd1 = v.d1; pd2 = v.d2; pi1 = v.i1; pi2 = v.i2;
        do_arm(v.div, v.pre, v.mask, v.value, v.edge_mode);
        wait_done($sformatf("v%0d done", k));
        check($sformatf("v%0d triggered", k), {31'd0, triggered}, 32'd1);
        check($sformatf("v%0d trig_addr", k), {28'd0, trig_addr}, {28'd0, v.exp_trig});
        check($sformatf("v%0d start_addr", k), {28'd0, start_addr}, {28'd0, v.exp_start});
        check($sformatf("v%0d busy", k), {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check($sformatf("v%0d writes", k), wr_count, v.exp_writes);
        check($sformatf("v%0d idle_enable", k), {31'd0, samp_enable}, 32'd0);
        check($sformatf("v%0d first_latency", k), first_wr - arm_cyc, 32'd2);
        check($sformatf("v%0d gap_err", k), gap_err, 32'd0);
        check($sformatf("v%0d addr_err", k), addr_err, 32'd0);
        check($sformatf("v%0d trig_data", k), {24'd0, mem[v.exp_trig]}, {24'd0, v.exp_tdat});
        check($sformatf("v%0d oldest_data", k), {24'd0, mem[v.exp_start]},
              {24'd0, pat_of(v.exp_writes - N)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_err, we_err;
        resetn = 1'b0; arm = 1'b0; abort = 1'b0; clr = 1'b1;
        div = '0; pre_count = '0; trig_mask = '0; trig_value = '0; trig_edge = 1'b0;
        pd0 = 8'h00; pd1 = 8'h00; pd2 = 8'h00; pi1 = 1000; pi2 = 1000; gap = 1;

        //              div  pre  mask   val   edge  d0     d1     d2     i1  i2    trig start wr  tdat
        vecs[0] = '{16'd0, 4'd5, 8'h01, 8'h01, 1'b0, 8'h00, 8'h01, 8'h01, 8, 999, 4'd8, 4'd3, 19, 8'h01};
        vecs[1] = '{16'd0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h3C, 8'h3C, 999, 999, 4'd0, 4'd0, 16, 8'h3C};
        vecs[2] = '{16'd1, 4'd2, 8'h80, 8'h80, 1'b1, 8'h7F, 8'hFF, 8'hFF, 6, 999, 4'd6, 4'd4, 20, 8'hFF};
        vecs[3] = '{16'd0, 4'd15, 8'hFF, 8'h5A, 1'b0, 8'h00, 8'h5A, 8'h5A, 20, 999, 4'd4, 4'd5, 21, 8'h5A};
        vecs[4] = '{16'd2, 4'd3, 8'h0F, 8'h03, 1'b0, 8'h33, 8'h33, 8'h33, 999, 999, 4'd3, 4'd0, 16, 8'h33};
        vecs[5] = '{16'd0, 4'd2, 8'h01, 8'h01, 1'b1, 8'h01, 8'h00, 8'h01, 4, 7, 4'd7, 4'd5, 21, 8'h01};

        repeat (3) tick();
        check("reset_flags", {27'd0, busy, done, triggered, samp_enable, wr_en}, 32'd0);
        check("reset_addrs", {24'd0, trig_addr, start_addr}, 32'd0);
        resetn = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("idle_after_reset", {30'd0, busy, samp_enable}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(k, vecs[k]);
        end

        // div=3 pacing: enable on cycles 1,5,9 after arm, writes one cycle later
        pd0 = 8'h00; pi1 = 1000; pi2 = 1000;
        do_arm(16'd3, 4'd1, 8'hFF, 8'hFF, 1'b0);
        en_err = 0;
        we_err = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (samp_enable != ((k % 4) == 1)) en_err++;
            if (wr_en != ((k % 4) == 2)) we_err++;
        end
        check("div3_enable_pattern", en_err, 32'd0);
        check("div3_write_pattern", we_err, 32'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("div3_abort_idle", {31'd0, busy}, 32'd0);

        // Edge mode with input held at the matching level, then a 0->1 on bit7
        pd0 = 8'hFF; pi1 = 30; pd1 = 8'h7F; pi2 = 33; pd2 = 8'hFF;
        do_arm(16'd0, 4'd0, 8'h80, 8'h80, 1'b1);
        wait_writes("edge_hold_writes", 25);
        check("edge_hold_busy", {31'd0, busy}, 32'd1);
        check("edge_hold_not_triggered", {31'd0, triggered}, 32'd0);
        wait_done("edge_done");
        check("edge_trig_addr", {28'd0, trig_addr}, 32'd1);
        check("edge_start_addr", {28'd0, start_addr}, 32'd1);
        repeat (4) @(negedge clk);
        check("edge_writes", wr_count, 32'd49);

        // Abort in WAIT (arm in the same cycle must lose), then a fresh capture
        pd0 = 8'h00; pi1 = 1000; pi2 = 1000;
        do_arm(16'd1, 4'd2, 8'hFF, 8'hAA, 1'b0);
        wait_writes("abort_pre_writes", 6);
        tick();
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_flags", {28'd0, busy, samp_enable, wr_en, done}, 32'd0);
        check("abort_trig_hold", {27'd0, triggered, trig_addr}, 32'd1);
        pd0 = 8'h5C;
        do_arm(16'd0, 4'd0, 8'h00, 8'h00, 1'b0);
        wait_done("rearm_done");
        check("rearm_trig_addr", {28'd0, trig_addr}, 32'd0);
        repeat (4) @(negedge clk);
        check("rearm_latency", first_wr - arm_cyc, 32'd2);
        check("rearm_addr_err", addr_err, 32'd0);
        check("rearm_writes", wr_count, 32'd16);

        // Reset in POST clears everything at once; a following capture is normal
        pd0 = 8'h00; pi1 = 8; pd1 = 8'h01; pd2 = 8'h01; pi2 = 999;
        do_arm(16'd0, 4'd5, 8'h01, 8'h01, 1'b0);
        wait_writes("post_reset_writes", 12);
        check("post_reset_in_post", {31'd0, triggered}, 32'd1);
        resetn = 1'b0;
        #1;
        check("async_reset_flags", {27'd0, busy, done, triggered, samp_enable, wr_en}, 32'd0);
        check("async_reset_addrs", {24'd0, trig_addr, start_addr}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        run_vec(6, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the 8-channel logic analyzer. It generates the `sampler` enable at a programmable rate, streams valid samples into a circular capture RAM, and detects a masked pattern/edge trigger. It stops after a fixed post-trigger count, so the RAM holds the pre-trigger and post-trigger windows around the trigger. It sits between the host control registers, the `sampler` instance and the capture RAM write port.

## Interface
- `DEPTH_W`, 10: log2 of capture RAM depth (N = 2^DEPTH_W samples).
- `DIV_W`, 16: width of the sample-rate divider.

- `clk`  in  1  system clock (27 MHz)
- `resetn`  in  1  reset, active-low (asynchronous assert)
- `arm`  in  1  start capture pulse (accepted in IDLE or DONE)
- `abort`  in  1  return to IDLE from any state
- `div`  in  DIV_W  sample period minus one, in clk cycles
- `pre_count`  in  DEPTH_W  pre-trigger samples to keep
- `trig_mask`  in  8  channels participating in the trigger
- `trig_value`  in  8  required level on masked channels
- `trig_edge`  in  1  1 = trigger on transition into match; 0 = level match
- `samp_enable`  out  1  to sampler `enable`
- `samp_data`  in  8  from sampler `data_out`
- `samp_valid`  in  1  from sampler `valid` (one cycle after `samp_enable`)
- `wr_en`  out  1  RAM write strobe
- `wr_addr`  out  DEPTH_W  RAM write address
- `wr_data`  out  8  RAM write data
- `busy`  out  1  state is PRE, WAIT or POST
- `triggered`  out  1  trigger seen in current capture
- `done`  out  1  state is DONE
- `trig_addr`  out  DEPTH_W  RAM address holding the trigger sample
- `start_addr`  out  DEPTH_W  address of oldest sample (valid when `done`)

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. Reset: IDLE; all outputs 0; all counters, pointer and the previous-sample register cleared.
- IDLE/DONE + `arm` latches `div`, `pre_count`, `trig_*` into shadow registers. It clears the pointer, counters and `triggered`, then goes to PRE, or to WAIT directly if `pre_count`==0.
- Config inputs are ignored outside the arm cycle.
- Divider: `samp_enable`=1 in the first active cycle, then every div+1 cycles while busy. In DONE, IDLE and after abort it is 0.
- Write path, combinational:
  - `wr_en` = `samp_valid` & `busy`.
  - `wr_data` = `samp_data`.
  - `wr_addr` = pointer.
  - Each write increments the pointer modulo N.
  - A trailing `samp_valid` after leaving busy is not written.
- PRE: counts writes; after the `pre_count`-th write, goes to WAIT.
- WAIT: every write is a trigger candidate.
  - match = ((`samp_data` ^ `trig_value`) & `trig_mask`)==0.
  - Level mode triggers on match. `trig_mask`==0 therefore triggers on the first WAIT sample.
  - Edge mode triggers on match & previous written sample existed & previous sample did not match.
  - The previous-sample register updates on every write.
- On trigger:
  - `trig_addr` captures the current `wr_addr` and `triggered` is set.
  - If N-1-`pre_count` is 0, go to DONE; otherwise go to POST with remaining = N-1-`pre_count`.
- POST: decrements remaining on each write; the write that brings it to 0 goes to DONE.
- DONE: `start_addr` = pointer (oldest sample, since at least N samples were written). Outputs hold until `arm` or `abort`.
- `abort` has priority over everything, including same-cycle `arm` or trigger. The next state is IDLE, the current-cycle write still occurs, and `triggered` and `trig_addr` hold.

## Timing
- `arm` at cycle 0 → `busy`=1 and `samp_enable`=1 at cycle 1 → first `wr_en` at cycle 2, address 0.
- With `div`=D, writes occur every D+1 cycles.
- Trigger sample: `trig_addr` and `triggered` are updated on the clock edge ending its write cycle.
- The last POST write cycle is followed by `done`=1 and `busy`=0 in the next cycle.

## Test plan
- DEPTH_W=4, `div`=0, `pre_count`=5, level `trig_mask`=0x01 `trig_value`=0x01, bit0 rises at the 9th sample → `trig_addr`=8, 10 post writes, `done`; `start_addr`=3, 16 valid samples around trigger.
- `div`=3 → `samp_enable` exactly 1 cycle in 4, `wr_en` every 4th cycle starting cycle 2 after `arm`.
- Edge mode, input held at 0xFF, mask 0x80 value 0x80 → never triggers, `busy` stays 1; toggle bit7 0→1 → trigger on first matching sample.
- `pre_count`=0, `trig_mask`=0 → trigger on first sample, `trig_addr`=0, done after 16 writes, no trailing write after DONE.
- `abort` mid-WAIT → IDLE next cycle, `samp_enable`=0, `wr_en`=0; re-`arm` restarts at address 0.
- `resetn` low mid-POST → all outputs 0 immediately; after release, `arm` yields a normal capture.
